cipher_frame_packer: RTL and testbench

Downstream consumer of the PUF cipher core. On a `start` pulse it captures a frame of consecutive encoded characters and the PUF key byte, buffers them, and emits them as a checksummed byte stream over a valid/ready interface toward the chip's serial/readout path. Each frame is header, key, data bytes (high byte first) and an XOR checksum.

---
 rtl/cipher_frame_packer.sv | 133 +++++++++++++
 tb/tb_cipher_frame_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cipher_frame_packer.sv
// cipher_frame_packer: captures a frame of cipher characters plus the PUF key and streams it as a checksummed byte frame
module cipher_frame_packer #(
   parameter int         FRAME_WORDS = 8,
   parameter logic [7:0] HEADER      = 8'hA5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] encoded_char,
   input  logic [7:0]  puf_response,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  frame_count
);
   localparam int IW = $clog2(FRAME_WORDS);
   localparam int BW = IW + 1;
   localparam logic [IW-1:0] LAST_W = IW'(FRAME_WORDS - 1);
   localparam logic [BW-1:0] LAST_B = BW'(2 * FRAME_WORDS - 1);
   typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_HEADER, S_KEY, S_DATA, S_CHECK} state_t;
   state_t state_q, state_d;
   logic [15:0] word_q [FRAME_WORDS];
   logic [15:0] word_d [FRAME_WORDS];
   logic [7:0] key_q, key_d, chk_q, chk_d, out_data_q, out_data_d, count_q, count_d, nxt_byte;
   logic [IW-1:0] widx_q, widx_d;
   logic [BW-1:0] bidx_q, bidx_d, nb;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d, done_q, done_d, hs;
   assign hs = out_valid_q & out_ready;
   assign nb = bidx_q + 1'b1;
   assign nxt_byte = nb[0] ? word_q[nb[BW-1:1]][7:0] : word_q[nb[BW-1:1]][15:8];
   assign out_data = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last = out_last_q;
   assign busy = busy_q;
   assign frame_done = done_q;
   assign frame_count = count_q;
   // next-state: capture words back to back, then advance one byte per handshake while folding it into the checksum
   always_comb begin
      state_d = state_q;
      word_d = word_q;
      key_d = key_q;
      widx_d = widx_q;
      bidx_d = bidx_q;
      chk_d = chk_q;
      out_data_d = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d = out_last_q;
      busy_d = busy_q;
      done_d = 1'b0;
      count_d = count_q;
      case (state_q)
         S_IDLE: if (start) begin
            word_d[0] = encoded_char;
            key_d = puf_response;
            widx_d = IW'(1);
            chk_d = '0;
            busy_d = 1'b1;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            word_d[widx_q] = encoded_char;
            widx_d = widx_q + 1'b1;
            if (widx_q == LAST_W) begin
               state_d = S_HEADER;
               out_valid_d = 1'b1;
               out_data_d = HEADER;
            end
         end
         default: if (hs) begin
            chk_d = chk_q ^ out_data_q;
            case (state_q)
               S_HEADER: begin
                  state_d = S_KEY;
                  out_data_d = key_q;
               end
               S_KEY: begin
                  state_d = S_DATA;
                  bidx_d = '0;
                  out_data_d = word_q[0][15:8];
               end
               S_DATA: begin
                  bidx_d = nb;
                  out_data_d = (bidx_q == LAST_B) ? chk_q ^ out_data_q : nxt_byte;
                  out_last_d = bidx_q == LAST_B;
                  state_d = (bidx_q == LAST_B) ? S_CHECK : S_DATA;
               end
               default: begin
                  state_d = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d = 1'b0;
                  out_data_d = '0;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  count_d = count_q + 1'b1;
               end
            endcase
         end
      endcase
   end
   // registers; reset abandons any frame in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         word_q <= '{default: '0};
         key_q <= '0;
         widx_q <= '0;
         bidx_q <= '0;
         chk_q <= '0;
         out_data_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         word_q <= word_d;
         key_q <= key_d;
         widx_q <= widx_d;
         bidx_q <= bidx_d;
         chk_q <= chk_d;
         out_data_q <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q <= out_last_d;
         busy_q <= busy_d;
         done_q <= done_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_cipher_frame_packer.sv
// tb_cipher_frame_packer: randomized self-checking bench with a queue-based frame model
module tb_cipher_frame_packer;
   localparam int N = 8;
   localparam logic [7:0] HDR = 8'hA5;
   logic clock = 0, reset = 0, start = 0, out_ready = 0;
   logic [15:0] encoded_char = 0;
   logic [7:0] puf_response = 0;
   logic [7:0] out_data, frame_count;
   logic out_valid, out_last, busy, frame_done;
   int n_checks = 0, n_fail = 0, cyc = 0, rdy_mode = 0, ec_mode = 0, st_mode = 0;
   logic [7:0] got[$];
   logic [7:0] ref_frame[$];
   logic [7:0] m_q[$];
   logic [15:0] m_words[$];
   logic [7:0] m_key = 0, m_count = 0, m_x = 0;
   logic m_busy = 0, m_done = 0;
   int m_cap = 0;

   cipher_frame_packer #(.FRAME_WORDS(N), .HEADER(HDR)) dut (
      .clock(clock), .reset(reset), .start(start), .encoded_char(encoded_char),
      .puf_response(puf_response), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy),
      .frame_done(frame_done), .frame_count(frame_count));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame model: a capture countdown, then a queue of the bytes still owed to the stream
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_q = {}; m_words = {}; m_cap = 0; m_busy = 0; m_done = 0; m_count = 0;
      end else begin
         m_done = 0;
         if (m_q.size() > 0) begin
            if (out_ready) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) begin
                  m_done = 1; m_busy = 0; m_count = m_count + 8'd1;
               end
            end
         end else if (m_cap > 0) begin
            m_words.push_back(encoded_char);
            m_cap--;
            if (m_cap == 0) begin
               m_q = {HDR, m_key};
               m_x = HDR ^ m_key;
               foreach (m_words[i]) begin
                  m_q.push_back(m_words[i][15:8]);
                  m_q.push_back(m_words[i][7:0]);
                  m_x = m_x ^ m_words[i][15:8] ^ m_words[i][7:0];
               end
               m_q.push_back(m_x);
            end
         end else if (start) begin
            m_words = {encoded_char}; m_key = puf_response; m_cap = N - 1; m_busy = 1;
         end
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clock) begin
      chk("valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         chk("data", out_data, m_q[0]);
         chk("last", out_last, m_q.size() == 1);
      end else chk("last_idle", out_last, 0);
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("frame_count", frame_count, m_count);
      if (out_valid && out_ready) got.push_back(out_data);
   end

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) :
                  rdy_mode == 2 ? 1'($urandom % 2) : 1'(cyc % 2);
      if (ec_mode == 1) encoded_char = encoded_char + 16'd1;
      else if (ec_mode == 2) encoded_char = 16'($urandom);
      if (st_mode == 1) begin
         start = ($urandom % 4) == 0;
         puf_response = 8'($urandom);
      end
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 600; i++) begin
         step();
         if (frame_done) break;
      end
      if (i == 600) chk("timeout", frame_done, 1);
   endtask

   task automatic run_frame(input logic [7:0] key, input logic [15:0] ec, input int ec_m, input int r_m, input int start_len);
      got = {};
      puf_response = key; encoded_char = ec; ec_mode = ec_m; rdy_mode = r_m; start = 1;
      for (int i = 0; i < start_len; i++) step();
      start = 0;
      wait_done();
   endtask

   initial begin
      int hs;
      logic [7:0] k;
      #1 reset = 1;
      repeat (3) step();
      chk("rst_data", out_data, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_count", frame_count, 0);
      reset = 0;
      rdy_mode = 3;
      repeat (20) step();
      chk("idle_valid", out_valid, 0);
      chk("idle_count", frame_count, 0);

      run_frame(8'h00, 16'h0000, 0, 0, 1);
      chk("zero_len", got.size(), 19);
      chk("zero_b0", got[0], 8'hA5);
      chk("zero_b1", got[1], 8'h00);
      chk("zero_b10", got[10], 8'h00);
      chk("zero_b18", got[18], 8'hA5);
      chk("zero_count", frame_count, 1);

      run_frame(8'h3C, 16'h1234, 0, 0, 1);
      chk("kd_len", got.size(), 19);
      chk("kd_b1", got[1], 8'h3C);
      chk("kd_b2", got[2], 8'h12);
      chk("kd_b3", got[3], 8'h34);
      chk("kd_b17", got[17], 8'h34);
      chk("kd_b18", got[18], 8'h99);
      ref_frame = got;

      run_frame(8'h3C, 16'h1234, 0, 1, 1);
      chk("bp_len", got.size(), 19);
      foreach (ref_frame[i]) chk($sformatf("bp_b%0d", i), got[i], ref_frame[i]);

      run_frame(8'h5A, 16'h0100, 1, 0, 12);
      chk("cap_b2", got[2], 8'h01);
      chk("cap_b3", got[3], 8'h00);
      chk("cap_b5", got[5], 8'h01);
      chk("cap_b17", got[17], 8'h07);
      chk("cap_b18", got[18], 8'hFF);
      ec_mode = 0;
      repeat (30) step();
      chk("cap_one_frame", frame_count, 4);

      st_mode = 1; ec_mode = 2; rdy_mode = 2;
      repeat (2000) step();
      st_mode = 0; start = 0;
      for (int i = 0; i < 400 && busy; i++) step();
      chk("rand_settle", busy, 0);

      got = {}; hs = 0; rdy_mode = 0; puf_response = 8'h77; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 100 && hs < 5; i++) begin
         step();
         if (out_valid && out_ready) hs++;
      end
      step();
      reset = 1;
      step(); step();
      reset = 0;
      chk("abort_hs", hs, 5);
      chk("abort_count", frame_count, 0);
      chk("abort_valid", out_valid, 0);
      k = 8'($urandom);
      run_frame(k, 16'h0, 2, 2, 1);
      chk("restart_b0", got[0], 8'hA5);
      chk("restart_b1", got[1], k);
      chk("restart_count", frame_count, 1);

      for (int f = 0; f < 255; f++) begin
         if (f == 254) chk("pre_wrap", frame_count, 255);
         run_frame(8'($urandom), 16'h0, 2, 2, 1);
      end
      chk("wrap_count", frame_count, 0);
      repeat (5) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
